// File: rtl/pipe_main_dec.sv
// -----------------------------------------------------------------------------
// pipe_main_dec
//
// Pipelined MIPS main decoder. The ID-stage opcode is decoded into the
// control bundle, which is then carried through the ID/EX, EX/MEM and MEM/WB
// control registers. Each register keeps only the fields that later stages
// still need. The block also detects load-use hazards and inserts bubbles,
// squashes younger instructions on a taken branch, freezes on an external
// hold, and counts inserted bubbles in a saturating counter.
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   id_valid                   IF/ID holds a real instruction
//   id_op, id_rs, id_rt        ID-stage opcode and register specifiers
//   hold                       external stall, all control registers freeze
//   flush                      branch taken in MEM, squash ID/EX and EX/MEM
//   id_jump, id_illegal        combinational decode flags (gated by id_valid)
//   stall_id                   load-use stall request to the PC and IF/ID
//   ex_regdst, ex_alusrc,
//   ex_aluop, ex_rt            EX-stage controls and the registered rt
//   mem_branch, mem_memwrite   MEM-stage controls
//   wb_memtoreg, wb_regwrite   WB-stage controls
//   bubble_cnt                 saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module pipe_main_dec #(
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [OP_W-1:0]    id_op,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               hold,
  input  logic               flush,
  output logic               id_jump,
  output logic               id_illegal,
  output logic               stall_id,
  output logic               ex_regdst,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_rt,
  output logic               mem_branch,
  output logic               mem_memwrite,
  output logic               wb_memtoreg,
  output logic               wb_regwrite,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Full control bundle as produced by the decoder and held in ID/EX.
  typedef struct packed {
    logic               regwrite;
    logic               regdst;
    logic               alusrc;
    logic               branch;
    logic               memwrite;
    logic               memtoreg;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  // Fields still needed once the instruction has left EX.
  typedef struct packed {
    logic branch;
    logic memwrite;
    logic memtoreg;
    logic regwrite;
  } exmem_t;

  // Fields still needed in WB.
  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } memwb_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  // ---------------------------------------------------------------------------
  // ID-stage decode
  // ---------------------------------------------------------------------------
  ctrl_t dec_ctrl;
  logic  dec_jump;
  logic  dec_known;
  ctrl_t id_ctrl;

  always_comb begin
    // NOTE: every signal written here gets a default before the case so that
    // no path leaves it unassigned; an unassigned path would infer a latch.
    dec_ctrl  = '0;
    dec_jump  = 1'b0;
    dec_known = 1'b1;
    case (id_op)
      OP_RTYPE: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.regdst   = 1'b1;
        dec_ctrl.aluop    = ALU_FUNCT;
      end
      OP_LW: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.memtoreg = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      OP_SW: begin
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.memwrite = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.aluop    = ALU_SUB;
      end
      OP_ADDI: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      OP_J: begin
        // The jump is resolved in ID; it writes nothing downstream.
        dec_jump = 1'b1;
      end
      default: begin
        dec_known = 1'b0;
      end
    endcase
  end

  // An empty IF/ID slot decodes to a harmless all-zero bundle.
  assign id_ctrl    = id_valid ? dec_ctrl : '0;
  assign id_jump    = id_valid & dec_jump;
  assign id_illegal = id_valid & ~dec_known;

  // ---------------------------------------------------------------------------
  // Pipeline control registers
  // ---------------------------------------------------------------------------
  ctrl_t            idex_q,  idex_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  // Only R-type, sw and beq actually read rt as a source; lw and addi use rt
  // as their destination, so a match on rt is not a hazard for them.
  logic uses_rt;
  logic load_use;

  assign uses_rt = (id_op == OP_RTYPE) | (id_op == OP_SW) | (id_op == OP_BEQ);

  // A load into $zero never produces a value anyone waits for.
  assign load_use = idex_q.memtoreg
                  & (ex_rt_q != '0)
                  & ((ex_rt_q == id_rs) | ((ex_rt_q == id_rt) & uses_rt))
                  & id_valid;

  // A hold freezes everything and a flush squashes the consumer anyway, so
  // either one makes the stall request meaningless.
  assign stall_id = load_use & ~hold & ~flush;

  // ---------------------------------------------------------------------------
  // Next-state selection, priority flush > hold > stall > advance
  // ---------------------------------------------------------------------------
  logic bubble_inc;

  // A flush inserts a bubble even when it coincides with a hold.
  assign bubble_inc = flush | stall_id;

  always_comb begin
    // Default is to keep every register, which is exactly the hold behaviour.
    idex_d   = idex_q;
    ex_rt_d  = ex_rt_q;
    exmem_d  = exmem_q;
    memwb_d  = memwb_q;
    bubble_d = bubble_q;

    if (flush) begin
      // The branch sits in MEM and retires normally; everything younger goes.
      idex_d   = '0;
      ex_rt_d  = '0;
      exmem_d  = '0;
      memwb_d  = '{memtoreg: exmem_q.memtoreg, regwrite: exmem_q.regwrite};
    end else if (hold) begin
      // Keep all values.
    end else if (stall_id) begin
      // Bubble into EX; the load and older instructions keep moving.
      idex_d   = '0;
      ex_rt_d  = '0;
      exmem_d  = '{branch:   idex_q.branch,   memwrite: idex_q.memwrite,
                   memtoreg: idex_q.memtoreg, regwrite: idex_q.regwrite};
      memwb_d  = '{memtoreg: exmem_q.memtoreg, regwrite: exmem_q.regwrite};
    end else begin
      idex_d   = id_ctrl;
      ex_rt_d  = id_valid ? id_rt : '0;
      exmem_d  = '{branch:   idex_q.branch,   memwrite: idex_q.memwrite,
                   memtoreg: idex_q.memtoreg, regwrite: idex_q.regwrite};
      memwb_d  = '{memtoreg: exmem_q.memtoreg, regwrite: exmem_q.regwrite};
    end

    // Saturate at all-ones rather than wrapping back to zero.
    if (bubble_inc && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge value of its neighbour, which is what makes the
  // stage-to-stage shift behave like a pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q   <= '0;
      ex_rt_q  <= '0;
      exmem_q  <= '0;
      memwb_q  <= '0;
      bubble_q <= '0;
    end else begin
      idex_q   <= idex_d;
      ex_rt_q  <= ex_rt_d;
      exmem_q  <= exmem_d;
      memwb_q  <= memwb_d;
      bubble_q <= bubble_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_regdst    = idex_q.regdst;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_aluop     = idex_q.aluop;
  assign ex_rt        = ex_rt_q;
  assign mem_branch   = exmem_q.branch;
  assign mem_memwrite = exmem_q.memwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_regwrite  = memwb_q.regwrite;
  assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_pipe_main_dec.sv
// -----------------------------------------------------------------------------
// tb_pipe_main_dec
//
// Directed bench for pipe_main_dec. A table-driven model tracks the full
// control bundle of whichever instruction occupies EX, MEM and WB, and a
// compare process checks every DUT output against it on each falling edge.
// A second instance with a 2-bit counter exercises saturation. Literal checks
// in the stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_main_dec;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       id_valid = 1'b0;
  logic [5:0] id_op = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;

  logic        id_jump, id_illegal, stall_id;
  logic        ex_regdst, ex_alusrc;
  logic [1:0]  ex_aluop;
  logic [4:0]  ex_rt;
  logic        mem_branch, mem_memwrite, wb_memtoreg, wb_regwrite;
  logic [15:0] bubble_cnt;

  logic        s_jump, s_illegal, s_stall, s_regdst, s_alusrc;
  logic [1:0]  s_aluop;
  logic [4:0]  s_rt;
  logic        s_branch, s_memwrite, s_memtoreg, s_regwrite;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  pipe_main_dec dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .hold(hold), .flush(flush),
    .id_jump(id_jump), .id_illegal(id_illegal), .stall_id(stall_id),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_memwrite(mem_memwrite),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
    .bubble_cnt(bubble_cnt)
  );

  pipe_main_dec #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .hold(hold), .flush(flush),
    .id_jump(s_jump), .id_illegal(s_illegal), .stall_id(s_stall),
    .ex_regdst(s_regdst), .ex_alusrc(s_alusrc), .ex_aluop(s_aluop),
    .ex_rt(s_rt), .mem_branch(s_branch), .mem_memwrite(s_memwrite),
    .wb_memtoreg(s_memtoreg), .wb_regwrite(s_regwrite),
    .bubble_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model. Bundle word layout, straight from the decode table:
  // {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, ALUOp[1:0]}
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] table_row(input logic v, input logic [5:0] op);
    if (!v) return 8'b0;
    case (op)
      RT:      return 8'b1_1_0_0_0_0_10;
      LW:      return 8'b1_0_1_0_0_1_00;
      SW:      return 8'b0_0_1_0_1_0_00;
      BEQ:     return 8'b0_0_0_1_0_0_01;
      ADDI:    return 8'b1_0_1_0_0_0_00;
      default: return 8'b0;
    endcase
  endfunction

  logic [7:0] m_ex = '0, m_mem = '0, m_wb = '0;
  logic [4:0] m_ex_rt = '0;
  int         m_cnt = 0;

  // Instruction in ID must wait if the load in EX writes a register it reads.
  function automatic logic model_stall();
    logic reads_rt;
    reads_rt = (id_op == RT) || (id_op == SW) || (id_op == BEQ);
    return id_valid && !hold && !flush && m_ex[2] && (m_ex_rt != 0)
           && ((m_ex_rt == id_rs) || (reads_rt && m_ex_rt == id_rt));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ex_rt = '0; m_cnt = 0;
    end else if (flush) begin
      m_wb = m_mem; m_mem = '0; m_ex = '0; m_ex_rt = '0; m_cnt++;
    end else if (hold) begin
      // frozen
    end else if (model_stall()) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = '0; m_ex_rt = '0; m_cnt++;
    end else begin
      m_wb = m_mem; m_mem = m_ex;
      m_ex = table_row(id_valid, id_op); m_ex_rt = id_rt;
    end
  end

  // Compare process, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic known;
      known = (id_op == RT) || (id_op == LW) || (id_op == SW) ||
              (id_op == BEQ) || (id_op == ADDI) || (id_op == JMP);
      check("id_jump",      32'(id_jump),      32'(id_valid && id_op == JMP));
      check("id_illegal",   32'(id_illegal),   32'(id_valid && !known));
      check("stall_id",     32'(stall_id),     32'(model_stall()));
      check("ex_regdst",    32'(ex_regdst),    32'(m_ex[6]));
      check("ex_alusrc",    32'(ex_alusrc),    32'(m_ex[5]));
      check("ex_aluop",     32'(ex_aluop),     32'(m_ex[1:0]));
      if (m_ex != 0) check("ex_rt", 32'(ex_rt), 32'(m_ex_rt));
      check("mem_branch",   32'(mem_branch),   32'(m_mem[4]));
      check("mem_memwrite", 32'(mem_memwrite), 32'(m_mem[3]));
      check("wb_memtoreg",  32'(wb_memtoreg),  32'(m_wb[2]));
      check("wb_regwrite",  32'(wb_regwrite),  32'(m_wb[7]));
      check("bubble_cnt",   32'(bubble_cnt),   (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
      check("sat_cnt",      32'(s_cnt),        (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic h, input logic f);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt; hold = h; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic h, input logic f);
    drive(v, op, rs, rt, h, f);
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #1;
    check("reset_bubble", 32'(bubble_cnt), 32'd0);
    check("reset_wb_rw",  32'(wb_regwrite), 32'd0);
    #19 rst_n = 1'b1;
    tick();

    // Straight-line ops, no hazards.
    step(1, LW, 5'd1, 5'd2, 0, 0);
    check("lw_ex_alusrc", 32'(ex_alusrc), 32'd1);
    check("lw_ex_regdst", 32'(ex_regdst), 32'd0);
    check("lw_ex_aluop",  32'(ex_aluop),  32'd0);
    check("lw_ex_rt",     32'(ex_rt),     32'd2);
    step(1, SW, 5'd3, 5'd4, 0, 0);
    check("sw_ex_alusrc", 32'(ex_alusrc), 32'd1);
    step(1, RT, 5'd5, 5'd6, 0, 0);
    check("lw_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
    check("lw_wb_regwrite", 32'(wb_regwrite), 32'd1);
    check("sw_mem_memwrite", 32'(mem_memwrite), 32'd1);
    check("r_ex_aluop", 32'(ex_aluop), 32'd2);
    step(1, BEQ, 5'd7, 5'd10, 0, 0);
    check("beq_ex_aluop", 32'(ex_aluop), 32'd1);
    step(1, ADDI, 5'd11, 5'd12, 0, 0);
    check("beq_mem_branch", 32'(mem_branch), 32'd1);
    repeat (3) step(0, RT, 5'd0, 5'd0, 0, 0);
    check("straight_bubbles", 32'(bubble_cnt), 32'd0);

    // Load-use on rs.
    step(1, LW, 5'd1, 5'd8, 0, 0);
    drive(1, RT, 5'd8, 5'd3, 0, 0);
    #1 check("lu_stall", 32'(stall_id), 32'd1);
    tick();
    check("lu_bubble_aluop", 32'(ex_aluop), 32'd0);
    check("lu_bubble_regdst", 32'(ex_regdst), 32'd0);
    check("lu_stall_clears", 32'(stall_id), 32'd0);
    tick();
    check("lu_cnt", 32'(bubble_cnt), 32'd1);
    check("lu_r_in_ex", 32'(ex_regdst), 32'd1);

    // Load into $zero is never a hazard.
    step(1, LW, 5'd1, 5'd0, 0, 0);
    drive(1, RT, 5'd0, 5'd0, 0, 0);
    #1 check("zero_no_stall", 32'(stall_id), 32'd0);
    tick();

    // sw reads rt, addi writes it.
    step(1, LW, 5'd1, 5'd9, 0, 0);
    drive(1, SW, 5'd3, 5'd9, 0, 0);
    #1 check("sw_rt_stall", 32'(stall_id), 32'd1);
    tick();
    tick();
    check("sw_cnt", 32'(bubble_cnt), 32'd2);
    step(1, LW, 5'd1, 5'd9, 0, 0);
    drive(1, ADDI, 5'd3, 5'd9, 0, 0);
    #1 check("addi_no_stall", 32'(stall_id), 32'd0);
    tick();

    // Flush together with hold.
    step(1, LW, 5'd1, 5'd2, 0, 0);
    step(1, SW, 5'd3, 5'd4, 0, 0);
    step(1, BEQ, 5'd5, 5'd6, 0, 0);
    check("pre_flush_memwrite", 32'(mem_memwrite), 32'd1);
    step(1, RT, 5'd2, 5'd3, 1, 1);
    check("flush_ex_aluop", 32'(ex_aluop), 32'd0);
    check("flush_mem_memwrite", 32'(mem_memwrite), 32'd0);
    check("flush_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
    check("flush_cnt", 32'(bubble_cnt), 32'd3);

    // Hold alone for three cycles, with a would-be hazard in ID.
    step(1, LW, 5'd1, 5'd2, 0, 0);
    step(1, RT, 5'd4, 5'd5, 0, 0);
    step(1, LW, 5'd6, 5'd7, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, RT, 5'd7, 5'd7, 1, 0);
      check("hold_ex_alusrc", 32'(ex_alusrc), 32'd1);
      check("hold_wb_memtoreg", 32'(wb_memtoreg), 32'd1);
      check("hold_cnt", 32'(bubble_cnt), 32'd3);
    end
    step(1, RT, 5'd7, 5'd7, 0, 0);
    step(1, RT, 5'd7, 5'd7, 0, 0);

    // Illegal, jump and invalid slot.
    drive(1, BAD, 5'd1, 5'd2, 0, 0);
    #1 check("illegal_flag", 32'(id_illegal), 32'd1);
    tick();
    check("illegal_ex_zero", 32'(ex_alusrc), 32'd0);
    drive(1, JMP, 5'd1, 5'd2, 0, 0);
    #1 check("jump_flag", 32'(id_jump), 32'd1);
    check("jump_not_illegal", 32'(id_illegal), 32'd0);
    tick();
    drive(0, BAD, 5'd1, 5'd2, 0, 0);
    #1 check("invalid_no_illegal", 32'(id_illegal), 32'd0);
    tick();
    drive(0, JMP, 5'd1, 5'd2, 0, 0);
    #1 check("invalid_no_jump", 32'(id_jump), 32'd0);
    tick();
    repeat (3) step(0, RT, 5'd0, 5'd0, 0, 0);
    check("illegal_wb_regwrite", 32'(wb_regwrite), 32'd0);

    // Asynchronous reset between edges.
    step(1, LW, 5'd1, 5'd2, 0, 0);
    step(1, RT, 5'd4, 5'd5, 0, 0);
    step(1, ADDI, 5'd6, 5'd7, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ex_alusrc", 32'(ex_alusrc), 32'd0);
    check("arst_ex_rt", 32'(ex_rt), 32'd0);
    check("arst_mem_memwrite", 32'(mem_memwrite), 32'd0);
    check("arst_wb_memtoreg", 32'(wb_memtoreg), 32'd0);
    check("arst_cnt", 32'(bubble_cnt), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Saturation of the 2-bit counter.
    step(1, RT, 5'd1, 5'd2, 0, 1);
    step(1, RT, 5'd1, 5'd2, 0, 1);
    check("sat_two", 32'(s_cnt), 32'd2);
    repeat (3) step(1, RT, 5'd1, 5'd2, 0, 1);
    check("sat_three", 32'(s_cnt), 32'd3);
    check("main_five", 32'(bubble_cnt), 32'd5);
    step(0, RT, 5'd0, 5'd0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_main_dec.md
Name: pipe_main_dec

Overview:
- Pipelined successor of the single-cycle main decoder.
- Decodes the ID-stage opcode into the MIPS control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds addi and jump decode, an illegal-opcode flag, load-use hazard detection with bubble insertion, branch flush, external hold, and a saturating bubble counter.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- OP_W, 6, opcode width.
- REG_W, 5, register-specifier width.
- ALUOP_W, 2, ALUOp width.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_op  in  OP_W  ID opcode.
- id_rs  in  REG_W  ID rs field.
- id_rt  in  REG_W  ID rt field.
- hold  in  1  external stall: all control registers freeze.
- flush  in  1  branch taken in MEM: squash younger instructions.
- id_jump  out  1  combinational jump decode of id_op, gated by id_valid.
- id_illegal  out  1  combinational: id_valid and opcode not in decode table.
- stall_id  out  1  combinational load-use stall request to PC and IF/ID.
- ex_regdst, ex_alusrc  out  1 each  EX-stage controls.
- ex_aluop  out  ALUOP_W  EX-stage ALU operation class.
- ex_rt  out  REG_W  registered rt of the instruction in EX.
- mem_branch, mem_memwrite  out  1 each  MEM-stage controls.
- wb_memtoreg, wb_regwrite  out  1 each  WB-stage controls.
- bubble_cnt  out  CNT_W  count of bubbles inserted (load-use plus flush).

Behaviour:
- Decode table (RegWrite RegDst ALUSrc Branch MemWrite MemtoReg ALUOp):
  - R-type 000000: 1 1 0 0 0 0 10.
  - lw 100011: 1 0 1 0 0 1 00.
  - sw 101011: 0 0 1 0 1 0 00.
  - beq 000100: 0 0 0 1 0 0 01.
  - addi 001000: 1 0 1 0 0 0 00.
  - j 000010: all zero, id_jump=1.
  - Any other opcode: all zero, id_illegal=1.
  - id_valid=0 yields an all-zero bundle.
- Internal ID/EX register holds the full bundle plus rt. EX/MEM holds branch, memwrite, memtoreg, regwrite. MEM/WB holds memtoreg, regwrite.
- Latency: the decoded bundle reaches the ex_* outputs 1 edge after ID, mem_* after 2 edges, wb_* after 3 edges.
- Load-use stall:
  - stall_id = ID/EX memtoreg & ex_rt != 0 & (ex_rt == id_rs | (ex_rt == id_rt & op in {R-type, sw, beq})) & id_valid.
  - Stall is suppressed when hold or flush is 1.
- Per-edge priority: reset > flush > hold > stall_id > advance.
  - flush: ID/EX and EX/MEM load zero bundles; MEM/WB advances normally from EX/MEM.
  - hold: all three registers keep their values; bubble_cnt unchanged.
  - stall_id: ID/EX loads a zero bundle (bubble); EX/MEM and MEM/WB advance.
  - Advance: each stage loads from the previous one.
- bubble_cnt:
  - +1 on each edge where flush=1, or where stall_id=1 and no hold.
  - Saturates at all-ones.
- Reset (asynchronous, mid-operation included): every registered output and bubble_cnt go to 0 immediately. Combinational outputs follow their inputs; stall_id is 0 while ID/EX is clear.
- ex_rt=0 never causes a stall, since $zero is never a hazard.

Test Plan:
- Straight-line ops: id_op=100011, then 101011, then 000000, 000100, 001000 on successive edges, no hazards -> ex_* shows lw at edge 1, and wb_memtoreg=1, wb_regwrite=1 at edge 3; every bundle matches the table; bubble_cnt=0.
- Load-use: lw with rt=8, then R-type with rs=8 -> stall_id=1 for one cycle; ID/EX bubble (ex_* all zero) on the next edge; bubble_cnt=1. Repeat with rt=0 -> no stall.
- sw/addi rt distinction: lw rt=9 followed by sw with rt=9, rs=3 -> stall. lw rt=9 followed by addi with rt=9, rs=3 -> no stall.
- Flush with hold: flush=1 and hold=1 on the same edge -> ID/EX and EX/MEM zeroed, MEM/WB advances, bubble_cnt+1. hold=1 alone for 3 cycles -> all outputs frozen.
- Illegal and jump: id_op=111111 -> id_illegal=1 and a zero bundle propagates. id_op=000010 -> id_jump=1, no writes. id_valid=0 -> both flags 0.
- Reset and saturation: assert rst_n=0 mid-pipeline between edges -> outputs zero without a clock edge. With CNT_W=2, 5 flushes -> bubble_cnt=3.
